serial_deser: RTL and testbench
===============================

# serial_deser

Serial-in/parallel-out receiver that reassembles words emitted one bit per cycle by the team's parallel-load shift-register transmitter, which shifts LSB first. It sits at the far end of that serial link. It frames each word on a start-of-frame marker, accumulates `WIDTH` bits with a bit counter, and holds the finished word in an output register under a valid/ready handshake.

## Interface
- `WIDTH`, default 8: data bits per word, must be ≥ 2.
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sin`, in, 1: serial data bit.
- `sin_valid`, in, 1: `sin` is meaningful this cycle.
- `sin_sof`, in, 1: this bit is bit 0 of a new word. Qualified by `sin_valid`.
- `sin_ready`, out, 1: receiver accepts a bit this cycle. A bit is accepted when `sin_valid && sin_ready`.
- `dout`, out, `WIDTH`: assembled word.
- `dout_valid`, out, 1: `dout` holds an unconsumed word.
- `dout_ready`, in, 1: consumer takes the word when `dout_valid && dout_ready`.
- `par_err`, out, 1: parity mismatch for the word currently in `dout`. Valid only with `dout_valid`.
- `frame_err`, out, 1: one-cycle pulse when a partial word is discarded by an early SOF.

## Operation
- States:
  - IDLE
  - SHIFT
  - PAR (present only with the macro)
  - FULL
- IDLE:
  - Accepted bits with `sin_sof`=0 are discarded.
  - An accepted bit with `sin_sof`=1 loads into the shifter MSB, sets count=1, and moves to SHIFT.
- SHIFT:
  - Each accepted bit shifts the shifter right, enters at the MSB, and increments count.
  - When count reaches `WIDTH`, the shifter copies to `dout` and the FSM goes to FULL, or to PAR when the macro is defined.
- Bit order: the k-th accepted bit lands in `dout[k]` (LSB first).
- Early SOF: an accepted bit with `sin_sof`=1 in SHIFT or PAR discards the partial word, pulses `frame_err`, and restarts with this bit as bit 0 (count=1).
- FULL:
  - `dout_valid`=1.
  - On handshake, `dout_valid` drops and the FSM goes to IDLE.
  - If a bit is also accepted that cycle, it is treated as in IDLE, so back-to-back words are possible.
- `sin_ready` = (state != FULL) | `dout_ready`. This is a combinational path from `dout_ready`.
- `dout` and `par_err` are stable while `dout_valid`=1 and not yet consumed.
- Counter width: $clog2(`WIDTH`+1). The counter never wraps, because it is cleared on each word.

## Timing
- Reset values:
  - state = IDLE, count = 0, shifter = 0.
  - `dout` = 0, `dout_valid` = 0, `par_err` = 0, `frame_err` = 0.
  - `sin_ready` = 1.
- Latency: `dout_valid` rises the cycle after the last data bit is accepted (no parity), or after the parity bit is accepted (parity enabled).
- Minimum word period: `WIDTH` cycles (no parity) or `WIDTH`+1 cycles (parity), with `dout_ready` held high.
- `frame_err` is registered and asserts the cycle after the offending SOF bit is accepted.
- Gaps (`sin_valid`=0) in SHIFT or PAR hold state and count indefinitely.
- Reset mid-word or while FULL discards everything and returns to reset values immediately.

## Configuration
- `SERIAL_DESER_PARITY_EN` defined:
  - After `WIDTH` data bits, the FSM enters PAR and accepts one even-parity bit, with `sin_sof`=0 expected.
  - `par_err` = (XOR of data bits) ^ parity bit, registered into FULL together with `dout`.
  - SOF on the parity slot counts as an early SOF.
- Not defined:
  - PAR state is absent.
  - `par_err` is tied to 0.
  - The word period is `WIDTH` bits.

## Structure
- Package `serial_deser_pkg`:
  - State enum (IDLE, SHIFT, PAR, FULL).
  - Default `WIDTH` constant.
  - Counter-width function.
- Sub-module `deser_shift_cell`: one shifter bit, made of a 2:1 select (hold vs shift-in) plus a flop with async active-low reset. It is instantiated `WIDTH` times by generate.
- The FSM, counter, output register and parity accumulator live in the top module.

## Test plan
- `WIDTH`=8, no macro:
  - Stimulus: SOF on the first bit, then bits 1,0,1,1,0,0,1,0 on consecutive cycles, `dout_ready`=1.
  - Response: `dout`=0x4D and `dout_valid`=1 for exactly one cycle, 8 cycles after the first bit.
- Backpressure:
  - Stimulus: `dout_ready`=0 after a word completes.
  - Response: `sin_ready`=0 and `dout` held at 0x4D. Raising `dout_ready` together with a new SOF bit consumes the word and starts the next one in the same cycle.
- Early SOF:
  - Stimulus: SOF, then 3 bits, then SOF, then 7 bits 1,1,1,1,1,1,1.
  - Response: `frame_err` pulses once, and `dout`=0xFF or 0xFE according to the bit given with the second SOF.
- Gaps and reset:
  - Stimulus: `sin_valid` toggled every other cycle.
  - Response: the same 0x4D word is produced.
  - Stimulus: `rst_n` low after bit 4.
  - Response: all outputs return to 0, and the next SOF frames a clean word.
- Macro defined:
  - Stimulus: 0x4D (four ones) with parity bit 0.
  - Response: `par_err`=0.
  - Stimulus: the same word with parity bit 1.
  - Response: `par_err`=1, with `dout_valid` arriving 9 cycles after the first bit.

Source files
------------

// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial_deser receiver.
package serial_deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_FULL  = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_shift_cell.sv
// One shifter bit: hold-or-shift select feeding an async-reset flop.
module deser_shift_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic shift_i,
  output logic q_o
);

  logic d;

  assign d = en_i ? shift_i : q_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= 1'b0;
    end else begin
      q_o <= d;
    end
  end

endmodule

// File: rtl/serial_deser.sv
// LSB-first serial-to-parallel receiver with SOF framing and valid/ready output.
// Optional even-parity slot after each word: define SERIAL_DESER_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for an accepted SOF bit
// SHIFT | collecting data bits, count = bits held so far
// PAR   | waiting for the parity bit (parity build only)
// FULL  | word held in dout, waiting for the consumer
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_sof,
  output logic             sin_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             par_err,
  output logic             frame_err
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_in;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             frame_err_q, frame_err_d;
  logic             shift_en;
  logic             restart;
  logic             accept;

`ifdef SERIAL_DESER_PARITY_EN
  logic par_acc_q, par_acc_d;
  logic par_err_q, par_err_d;
`endif

  assign sin_ready  = (state_q != ST_FULL) | dout_ready;
  assign accept     = sin_valid & sin_ready;
  assign dout       = dout_q;
  assign dout_valid = (state_q == ST_FULL);
  assign frame_err  = frame_err_q;

  // New bit enters at the MSB so the first bit of a word ends up in bit 0.
  assign shift_in = {sin, shift_q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    deser_shift_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (shift_en),
      .shift_i (shift_in[i]),
      .q_o     (shift_q[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    shift_en    = 1'b0;
    restart     = 1'b0;
    frame_err_d = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
    par_acc_d   = par_acc_q;
    par_err_d   = par_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept && sin_sof) begin
          restart = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (accept) begin
          if (sin_sof) begin
            restart     = 1'b1;
            frame_err_d = 1'b1;
          end else begin
            shift_en = 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
            par_acc_d = par_acc_q ^ sin;
`endif
            if (cnt_q == CNT_LAST) begin
              cnt_d  = '0;
              dout_d = shift_in;
`ifdef SERIAL_DESER_PARITY_EN
              state_d = ST_PAR;
`else
              state_d = ST_FULL;
`endif
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
      end

`ifdef SERIAL_DESER_PARITY_EN
      ST_PAR: begin
        if (accept) begin
          if (sin_sof) begin
            restart     = 1'b1;
            frame_err_d = 1'b1;
          end else begin
            par_err_d = par_acc_q ^ sin;
            state_d   = ST_FULL;
          end
        end
      end
`endif

      ST_FULL: begin
        // A bit accepted in the consuming cycle is handled as if already idle.
        if (dout_ready) begin
          state_d = ST_IDLE;
          if (accept && sin_sof) begin
            restart = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (restart) begin
      shift_en = 1'b1;
      cnt_d    = CNT_ONE;
      state_d  = ST_SHIFT;
`ifdef SERIAL_DESER_PARITY_EN
      par_acc_d = sin;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dout_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef SERIAL_DESER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_acc_q <= par_acc_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Directed self-checking bench for serial_deser (WIDTH=8), both parity builds.
module tb_serial_deser;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sin = 1'b0;
  logic             sin_valid = 1'b0;
  logic             sin_sof = 1'b0;
  logic             dout_ready = 1'b0;
  logic             sin_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             par_err;
  logic             frame_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_deser #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_sof    (sin_sof),
    .sin_ready  (sin_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .par_err    (par_err),
    .frame_err  (frame_err)
  );

  // Present one input cycle, then sample 1 time unit after the rising edge.
  task automatic drive(input logic b, input logic sof, input logic v);
    sin       = b;
    sin_sof   = sof;
    sin_valid = v;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sin_sof   = 1'b0;
    sin       = 1'b0;
  endtask

  // Full word, SOF on bit 0; parity build appends parity (flipped if asked).
  task automatic send_word(input logic [WIDTH-1:0] w, input logic par_flip);
    for (int k = 0; k < WIDTH; k++) drive(w[k], (k == 0), 1'b1);
`ifdef SERIAL_DESER_PARITY_EN
    drive((^w) ^ par_flip, 1'b0, 1'b1);
`else
    if (par_flip) $display("note: parity flip ignored in this build");
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %b exp 0", dout_valid); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err got %b exp 0", par_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    checks++; if (sin_ready !== 1'b1) begin errors++; $display("FAIL reset_sin_ready got %b exp 1", sin_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] w;
    w = 8'h4D;
    dout_ready = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      drive(w[k], (k == 0), 1'b1);
`ifdef SERIAL_DESER_PARITY_EN
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early k=%0d got %b exp 0", k, dout_valid); end
`else
      checks++; if (dout_valid !== (k == WIDTH - 1)) begin errors++; $display("FAIL basic_valid_timing k=%0d got %b exp %b", k, dout_valid, (k == WIDTH - 1)); end
`endif
    end
`ifdef SERIAL_DESER_PARITY_EN
    drive(^w, 1'b0, 1'b1);
`endif
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", dout_valid); end
    checks++; if (dout !== 8'h4D) begin errors++; $display("FAIL basic_dout got %h exp 4d", dout); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL basic_par_err got %b exp 0", par_err); end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_one_cycle got %b exp 0", dout_valid); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] w2;
    w2 = 8'hA5;
    dout_ready = 1'b0;
    send_word(8'h4D, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d got %b exp 1", c, dout_valid); end
      checks++; if (sin_ready !== 1'b0) begin errors++; $display("FAIL bp_sin_ready c=%0d got %b exp 0", c, sin_ready); end
      checks++; if (dout !== 8'h4D) begin errors++; $display("FAIL bp_dout_hold c=%0d got %h exp 4d", c, dout); end
      drive(1'b1, 1'b1, 1'b1);
    end
    dout_ready = 1'b1;
    #1;
    checks++; if (sin_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb got %b exp 1", sin_ready); end
    drive(w2[0], 1'b1, 1'b1);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed got %b exp 0", dout_valid); end
    for (int k = 1; k < WIDTH; k++) drive(w2[k], 1'b0, 1'b1);
`ifdef SERIAL_DESER_PARITY_EN
    drive(^w2, 1'b0, 1'b1);
`endif
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL bp_next_dout got %h exp a5", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got %b exp 1", dout_valid); end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_early_sof();
    int fe_cnt;
    logic [WIDTH-1:0] exp_w;
    dout_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      fe_cnt = 0;
      exp_w  = (b == 1) ? 8'hFF : 8'hFE;
      drive(1'b1, 1'b1, 1'b1); fe_cnt += int'(frame_err);
      drive(1'b1, 1'b0, 1'b1); fe_cnt += int'(frame_err);
      drive(1'b0, 1'b0, 1'b1); fe_cnt += int'(frame_err);
      drive(1'b1, 1'b0, 1'b1); fe_cnt += int'(frame_err);
      drive(b[0], 1'b1, 1'b1); fe_cnt += int'(frame_err);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL esof_pulse b=%0d got %b exp 1", b, frame_err); end
      for (int k = 1; k < WIDTH; k++) begin
        drive(1'b1, 1'b0, 1'b1); fe_cnt += int'(frame_err);
      end
`ifdef SERIAL_DESER_PARITY_EN
      drive(^exp_w, 1'b0, 1'b1); fe_cnt += int'(frame_err);
`endif
      checks++; if (fe_cnt != 1) begin errors++; $display("FAIL esof_pulse_count b=%0d got %0d exp 1", b, fe_cnt); end
      checks++; if (dout !== exp_w) begin errors++; $display("FAIL esof_dout b=%0d got %h exp %h", b, dout, exp_w); end
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL esof_valid b=%0d got %b exp 1", b, dout_valid); end
      drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_gaps();
    logic [WIDTH-1:0] w;
    int fe_cnt;
    w = 8'h4D;
    fe_cnt = 0;
    dout_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 1'b1); fe_cnt += int'(frame_err);
    end
    for (int k = 0; k < WIDTH; k++) begin
      drive(w[k], (k == 0), 1'b1); fe_cnt += int'(frame_err);
      if (k < WIDTH - 1) begin
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL gap_valid_early k=%0d got %b exp 0", k, dout_valid); end
        drive(~w[k], 1'b1, 1'b0); fe_cnt += int'(frame_err);
      end
    end
`ifdef SERIAL_DESER_PARITY_EN
    drive(1'b1, 1'b1, 1'b0); fe_cnt += int'(frame_err);
    drive(^w, 1'b0, 1'b1); fe_cnt += int'(frame_err);
`endif
    checks++; if (dout !== 8'h4D) begin errors++; $display("FAIL gap_dout got %h exp 4d", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got %b exp 1", dout_valid); end
    checks++; if (fe_cnt != 0) begin errors++; $display("FAIL gap_frame_err got %0d exp 0", fe_cnt); end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] w;
    int fe_cnt;
    w = 8'h3C;
    fe_cnt = 0;
    dout_ready = 1'b1;
    for (int k = 0; k < 5; k++) drive(k[0], (k == 0), 1'b1);
    rst_n = 1'b0;
    #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_mid_dout got %h exp 00", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", dout_valid); end
    checks++; if (sin_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_sin_ready got %b exp 1", sin_ready); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_err got %b exp 0", frame_err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      drive(w[k], (k == 0), 1'b1); fe_cnt += int'(frame_err);
    end
`ifdef SERIAL_DESER_PARITY_EN
    drive(^w, 1'b0, 1'b1);
`endif
    checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL rst_clean_dout got %h exp 3c", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL rst_clean_valid got %b exp 1", dout_valid); end
    checks++; if (fe_cnt != 0) begin errors++; $display("FAIL rst_clean_frame_err got %0d exp 0", fe_cnt); end
    dout_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_full_valid got %b exp 0", dout_valid); end
    checks++; if (sin_ready !== 1'b1) begin errors++; $display("FAIL rst_full_sin_ready got %b exp 1", sin_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef SERIAL_DESER_PARITY_EN
  task automatic test_parity();
    logic [WIDTH-1:0] w;
    w = 8'h4D;
    dout_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < WIDTH; k++) drive(w[k], (k == 0), 1'b1);
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL par_valid_early p=%0d got %b exp 0", p, dout_valid); end
      drive(p[0], 1'b0, 1'b1);
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL par_valid p=%0d got %b exp 1", p, dout_valid); end
      checks++; if (par_err !== p[0]) begin errors++; $display("FAIL par_err p=%0d got %b exp %b", p, par_err, p[0]); end
      checks++; if (dout !== 8'h4D) begin errors++; $display("FAIL par_dout p=%0d got %h exp 4d", p, dout); end
      drive(1'b0, 1'b0, 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_early_sof();
    test_gaps();
    test_reset_mid();
`ifdef SERIAL_DESER_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
